// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, keeps one instruction-memory request in flight,
// and hands words to the IF/ID register, with NOP bubbles when nothing is held.
module fetch_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h00000013)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallF,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [WIDTH-1:0] imem_rsp_data,
    output logic [WIDTH-1:0] InstrF,
    output logic [WIDTH-1:0] PCF,
    output logic [WIDTH-1:0] PCPlus4F,
    output logic [WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HAVE = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr_buf;
    logic [WIDTH-1:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc[WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            instr_buf   <= NOP_INSTR;
            fetch_count <= '0;
        end else if (redirect_valid) begin
            // A request still in flight after this edge must have its response discarded.
            pc <= redirect_tgt;
            case (state)
                S_REQ:          state <= imem_req_ready ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state <= imem_rsp_valid ? S_REQ : S_DROP;
                default:        state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_buf <= imem_rsp_data;
                        state     <= S_HAVE;
                    end
                end
                S_HAVE: begin
                    if (!StallF) begin
                        pc          <= pc + WIDTH'(4);
                        fetch_count <= fetch_count + WIDTH'(1);
                        state       <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = pc;
    assign PCF            = pc;
    assign PCPlus4F       = pc + WIDTH'(4);
    assign InstrF         = (state == S_HAVE) ? instr_buf : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// and a randomized run against an abstract fetch model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk, rst;
    logic        StallF, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrF, PCF, PCPlus4F, fetch_count;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk(clk), .rst(rst), .StallF(StallF),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .InstrF(InstrF), .PCF(PCF),
        .PCPlus4F(PCPlus4F), .fetch_count(fetch_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, rv, ready, rspv;
        logic [31:0] rpc, data;
        logic        e_rv;
        logic [31:0] e_instr, e_pc, e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic stall, logic rv, logic [31:0] rpc, logic ready,
                                logic rspv, logic [31:0] data, logic e_rv,
                                logic [31:0] e_instr, logic [31:0] e_pc, logic [31:0] e_cnt);
        vec_t v;
        v.stall = stall; v.rv = rv; v.rpc = rpc; v.ready = ready; v.rspv = rspv;
        v.data = data; v.e_rv = e_rv; v.e_instr = e_instr; v.e_pc = e_pc; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic stall, input logic rv, input logic [31:0] rpc,
                         input logic ready, input logic rspv, input logic [31:0] data);
        StallF = stall; redirect_valid = rv; redirect_pc = rpc;
        imem_req_ready = ready; imem_rsp_valid = rspv; imem_rsp_data = data;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic e_rv, input logic [31:0] e_instr,
                           input logic [31:0] e_pc, input logic [31:0] e_cnt);
        chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, e_rv});
        chk({tag, ".req_addr"}, imem_req_addr, e_pc);
        chk({tag, ".InstrF"}, InstrF, e_instr);
        chk({tag, ".PCF"}, PCF, e_pc);
        chk({tag, ".PCPlus4F"}, PCPlus4F, e_pc + 32'd4);
        chk({tag, ".fetch_count"}, fetch_count, e_cnt);
    endtask

    // Abstract model: an in-flight flag, a "discard" flag, and a held word.
    logic [31:0] m_pc, m_buf, m_cnt;
    bit          m_out, m_stale, m_have;

    task automatic model_reset();
        m_pc = 32'h0; m_buf = NOP; m_cnt = 0;
        m_out = 0; m_stale = 0; m_have = 0;
    endtask

    task automatic model_step(input logic stall, input logic rv, input logic [31:0] rpc,
                              input logic ready, input logic rspv, input logic [31:0] data);
        bit accepted;
        accepted = !m_out && !m_have && ready;
        if (rv) begin
            m_pc    = rpc & ~32'h3;
            m_have  = 0;
            m_out   = accepted || (m_out && !rspv);
            m_stale = m_out;
        end else if (m_have) begin
            if (!stall) begin
                m_have = 0;
                m_pc   = m_pc + 4;
                m_cnt  = m_cnt + 1;
            end
        end else if (m_out) begin
            if (rspv) begin
                if (!m_stale) begin
                    m_have = 1;
                    m_buf  = data;
                end
                m_out   = 0;
                m_stale = 0;
            end
        end else if (accepted) begin
            m_out   = 1;
            m_stale = 0;
        end
    endtask

    initial begin
        bit          pend;
        int          dly;
        logic        s, rv, rdy, rspv;
        logic [31:0] rpc, d;

        rst = 1;
        apply(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, NOP, 32'h0, 32'h0);
        rst = 0;

        //          stall rv  rpc        rdy rspv data          e_rv e_instr       e_pc       e_cnt
        vecs.push_back(mk(0, 0, 0,          1, 0, 0,            1, NOP,          32'h0,     0));
        vecs.push_back(mk(0, 0, 0,          0, 1, 32'h00500093, 0, NOP,          32'h0,     0));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,            0, 32'h00500093, 32'h0,     0));
        vecs.push_back(mk(0, 0, 0,          1, 0, 0,            1, NOP,          32'h4,     1));
        vecs.push_back(mk(0, 0, 0,          0, 1, 32'h00A00113, 0, NOP,          32'h4,     1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 0,      1, 0, 0,            0, 32'h00A00113, 32'h4,     1));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,            0, 32'h00A00113, 32'h4,     1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 0,      0, 0, 0,            1, NOP,          32'h8,     2));
        vecs.push_back(mk(0, 0, 0,          1, 0, 0,            1, NOP,          32'h8,     2));
        vecs.push_back(mk(0, 1, 32'h103,    0, 0, 0,            0, NOP,          32'h8,     2));
        vecs.push_back(mk(0, 0, 0,          0, 1, 32'hDEADBEEF, 0, NOP,          32'h100,   2));
        vecs.push_back(mk(0, 0, 0,          1, 0, 0,            1, NOP,          32'h100,   2));
        vecs.push_back(mk(0, 0, 0,          0, 1, 32'h11111111, 0, NOP,          32'h100,   2));
        vecs.push_back(mk(1, 1, 32'h40,     0, 0, 0,            0, 32'h11111111, 32'h100,   2));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,            1, NOP,          32'h40,    2));
        vecs.push_back(mk(0, 0, 0,          1, 0, 0,            1, NOP,          32'h40,    2));
        vecs.push_back(mk(0, 1, 32'h200,    0, 1, 32'h22222222, 0, NOP,          32'h40,    2));
        vecs.push_back(mk(0, 0, 0,          0, 0, 0,            1, NOP,          32'h200,   2));

        foreach (vecs[i]) begin
            apply(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].ready, vecs[i].rspv, vecs[i].data);
            chk_all($sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_cnt);
            tick();
        end

        // PC wrap at the top of the address space
        apply(0, 1, 32'hFFFFFFFF, 0, 0, 0); tick();
        apply(0, 0, 0, 1, 0, 0);
        chk_all("wrap.req", 1, NOP, 32'hFFFFFFFC, 2);
        tick();
        apply(0, 0, 0, 0, 1, 32'hABCD0001); tick();
        apply(0, 0, 0, 0, 0, 0);
        chk("wrap.PCPlus4F", PCPlus4F, 32'h0);
        chk("wrap.InstrF", InstrF, 32'hABCD0001);
        tick();
        apply(0, 0, 0, 1, 0, 0);
        chk_all("wrap.next", 1, NOP, 32'h0, 3);
        tick();

        // Asynchronous reset in WAIT, observed before any clock edge
        apply(0, 0, 0, 0, 0, 0);
        chk_all("wait.pre", 0, NOP, 32'h0, 3);
        rst = 1;
        #1;
        chk_all("async_rst", 0, NOP, 32'h0, 0);
        tick();
        rst = 0;

        // Randomized run against the model, with a memory of 1..3 cycle latency
        model_reset();
        pend = 0; dly = 0;
        for (int c = 0; c < 2000; c++) begin
            s    = ($urandom_range(0, 9) < 3);
            rv   = ($urandom_range(0, 19) == 0);
            rpc  = $urandom_range(0, 3) == 0 ? 32'hFFFFFFF0 | 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 4095));
            rdy  = ($urandom_range(0, 3) != 0);
            rspv = pend && dly == 0;
            d    = $urandom;
            apply(s, rv, rpc, rdy, rspv, d);
            assert (!(rspv && !m_out)) else $error("response driven with no request in flight");
            chk_all("rand", !m_out && !m_have, m_have ? m_buf : NOP, m_pc, m_cnt);
            tick();
            if (rspv) pend = 0;
            else if (pend) dly--;
            if (!m_out && !m_have && rdy) begin
                pend = 1;
                dly  = $urandom_range(0, 2);
            end
            model_step(s, rv, rpc, rdy, rspv, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
